// File: rtl/adc_dual_serial_reader_pkg.sv
// Shared types and sizing helpers for the dual serial ADC reader.
package adc_reader_pkg;

    localparam int unsigned NBITS_DEF      = 14;
    localparam int unsigned LEAD_ZEROS_DEF = 2;
    localparam int unsigned CLK_DIV_DEF    = 2;
    localparam int unsigned CS_SETUP_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        QUIET
    } state_t;

    function automatic int unsigned frame_len(input int unsigned nbits, input int unsigned lead);
        return nbits + lead;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_dual_serial_reader_if.sv
// Controller/ADC-pin bundle of the dual serial ADC reader; slave = reader, master = its environment.
interface adc_dual_serial_reader_if
    import adc_reader_pkg::*;
#(
    parameter int unsigned NBITS = NBITS_DEF
);
    logic             CE;
    logic             trigger;
    logic             adc_cs_n;
    logic             adc_sclk;
    logic             adc_sdo1;
    logic             adc_sdo2;
    logic [NBITS-1:0] Vdc1;
    logic [NBITS-1:0] Vdc2;
    logic             data_valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    modport slave (
        input  CE, trigger, adc_sdo1, adc_sdo2,
        output adc_cs_n, adc_sclk, Vdc1, Vdc2, data_valid, busy, frame_err, overrun
    );

    modport master (
        output CE, trigger, adc_sdo1, adc_sdo2,
        input  adc_cs_n, adc_sclk, Vdc1, Vdc2, data_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/adc_dual_serial_reader_shift_chan.sv
// One ADC channel: frame shift register, leading-zero check and output code register.
// Optional averaging of consecutive accepted codes when ADC_AVG_EN is defined.
module adc_shift_chan
    import adc_reader_pkg::*;
#(
    parameter int unsigned NBITS      = NBITS_DEF,
    parameter int unsigned LEAD_ZEROS = LEAD_ZEROS_DEF
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sdo_i,
    input  logic             shift_en_i,
    input  logic             accept_i,
    output logic             lead_err_o,
    output logic [NBITS-1:0] data_o
);
    localparam int unsigned FRAME_LEN = frame_len(NBITS, LEAD_ZEROS);

    logic [FRAME_LEN-1:0] sr_q, sr_d;
    logic [NBITS-1:0]     data_q, data_d;
    logic [NBITS-1:0]     raw;

    assign raw    = sr_q[NBITS-1:0];
    assign sr_d   = {sr_q[FRAME_LEN-2:0], sdo_i};
    assign data_o = data_q;

    generate
        if (LEAD_ZEROS > 0) begin : g_lead
            assign lead_err_o = |sr_q[FRAME_LEN-1 -: LEAD_ZEROS];
        end else begin : g_nolead
            assign lead_err_o = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else if (shift_en_i) begin
            sr_q <= sr_d;
        end
    end

`ifdef ADC_AVG_EN
    logic [NBITS-1:0] prev_q;
    logic             have_prev_q;
    logic [NBITS:0]   sum;

    assign sum = {1'b0, raw} + {1'b0, prev_q};

    // First accepted frame after reset has no history and passes through raw.
    always_comb begin
        data_d = raw;
        if (have_prev_q) begin
            data_d = sum[NBITS:1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else if (accept_i) begin
            prev_q      <= raw;
            have_prev_q <= 1'b1;
        end
    end
`else
    assign data_d = raw;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (accept_i) begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/adc_dual_serial_reader.sv
// Dual simultaneous-sampling serial ADC reader: shared CS/SCLK, one frame per trigger.
// Build option ADC_AVG_EN enables per-channel averaging of consecutive accepted codes.
module adc_dual_serial_reader
    import adc_reader_pkg::*;
#(
    parameter int unsigned NBITS      = NBITS_DEF,
    parameter int unsigned LEAD_ZEROS = LEAD_ZEROS_DEF,
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned CS_SETUP   = CS_SETUP_DEF
)(
    input logic                  clk,
    input logic                  rst,
    adc_dual_serial_reader_if.slave bus
);
    localparam int unsigned FRAME_LEN = frame_len(NBITS, LEAD_ZEROS);
    localparam int unsigned CNT_MAX   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned CNT_W     = cnt_width(CNT_MAX);
    localparam int unsigned BIT_W     = cnt_width(FRAME_LEN);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CLK_DIV - 2);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_LEN - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIT_W-1:0] bit_q;
    logic             cs_n_q, sclk_q, busy_q;
    logic             valid_q, ferr_q, ovr_q, trig_drop_q;

    logic div_done, last_bit, shift_en, commit, frame_ok;
    logic err1, err2;

    assign div_done = (cnt_q == DIV_LAST);
    assign last_bit = (bit_q == BIT_LAST);
    assign shift_en = bus.CE && (state_q == SHIFT) && !sclk_q && div_done;
    assign commit   = bus.CE && (state_q == QUIET);
    assign frame_ok = !(err1 || err2);

    // QUIET occupies the final clk of the last SCLK-high half, so results and CS release
    // land exactly CLK_DIV clks after the last rising SCLK and IDLE is reached on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            trig_drop_q <= 1'b0;
        end else if (bus.CE) begin
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            trig_drop_q <= (state_q != IDLE) && bus.trigger;
            ovr_q       <= trig_drop_q;
            case (state_q)
                IDLE: begin
                    if (bus.trigger) begin
                        state_q <= SETUP;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_q <= SHIFT;
                        sclk_q  <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (!sclk_q) begin
                        if (div_done) begin
                            sclk_q <= 1'b1;
                            cnt_q  <= '0;
                            if (CLK_DIV == 1 && last_bit) begin
                                state_q <= QUIET;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (last_bit) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_q <= QUIET;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (div_done) begin
                        sclk_q <= 1'b0;
                        cnt_q  <= '0;
                        bit_q  <= bit_q + BIT_W'(1);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                QUIET: begin
                    state_q <= IDLE;
                    cs_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= frame_ok;
                    ferr_q  <= !frame_ok;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    adc_shift_chan #(
        .NBITS      (NBITS),
        .LEAD_ZEROS (LEAD_ZEROS)
    ) ch1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .sdo_i      (bus.adc_sdo1),
        .shift_en_i (shift_en),
        .accept_i   (commit && frame_ok),
        .lead_err_o (err1),
        .data_o     (bus.Vdc1)
    );

    adc_shift_chan #(
        .NBITS      (NBITS),
        .LEAD_ZEROS (LEAD_ZEROS)
    ) ch2 (
        .clk_i      (clk),
        .rst_i      (rst),
        .sdo_i      (bus.adc_sdo2),
        .shift_en_i (shift_en),
        .accept_i   (commit && frame_ok),
        .lead_err_o (err2),
        .data_o     (bus.Vdc2)
    );

    assign bus.adc_cs_n   = cs_n_q;
    assign bus.adc_sclk   = sclk_q;
    assign bus.busy       = busy_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_adc_dual_serial_reader.sv
// Scenario bench for adc_dual_serial_reader with a behavioural dual-ADC model and a result scoreboard.
module tb_adc_dual_serial_reader;

    typedef struct packed {
        logic [13:0] v1;
        logic [13:0] v2;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    adc_dual_serial_reader_if #(.NBITS(14)) bus ();

    adc_dual_serial_reader #(
        .NBITS      (14),
        .LEAD_ZEROS (2),
        .CLK_DIV    (2),
        .CS_SETUP   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ADC model: CS fall arms the frame, each SCLK fall presents the next bit MSB first.
    logic [15:0] frame1, frame2;
    int          fidx = 15;

    always @(negedge bus.adc_cs_n) fidx = 15;

    always @(negedge bus.adc_sclk) begin
        if (!bus.adc_cs_n && fidx >= 0) begin
            bus.adc_sdo1 = frame1[fidx];
            bus.adc_sdo2 = frame2[fidx];
            fidx = fidx - 1;
        end
    end

    exp_t        sb[$];
    exp_t        mon_e;
    logic [13:0] m_v1 = '0, m_v2 = '0, m_p1 = '0, m_p2 = '0;
    logic        m_have = 1'b0;

    always @(negedge clk) begin
        if (!rst && (bus.data_valid || bus.frame_err)) begin
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL sb_unexpected got valid=%0b err=%0b want no result", bus.data_valid, bus.frame_err);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.data_valid, bus.frame_err, bus.Vdc1, bus.Vdc2} !== {!mon_e.err, mon_e.err, mon_e.v1, mon_e.v2}) begin
                    bad = bad + 1;
                    $display("FAIL sb_result got err=%0b v1=%0d v2=%0d want err=%0b v1=%0d v2=%0d",
                             bus.frame_err, bus.Vdc1, bus.Vdc2, mon_e.err, mon_e.v1, mon_e.v2);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_frame(input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [14:0] s;
        e.err = (a[15:14] != 2'b00) || (b[15:14] != 2'b00);
        if (!e.err) begin
`ifdef ADC_AVG_EN
            if (m_have) begin
                s = {1'b0, a[13:0]} + {1'b0, m_p1};
                m_v1 = s[14:1];
                s = {1'b0, b[13:0]} + {1'b0, m_p2};
                m_v2 = s[14:1];
            end else begin
                m_v1 = a[13:0];
                m_v2 = b[13:0];
            end
            m_p1 = a[13:0];
            m_p2 = b[13:0];
            m_have = 1'b1;
`else
            m_v1 = a[13:0];
            m_v2 = b[13:0];
`endif
        end
        e.v1 = m_v1;
        e.v2 = m_v2;
        sb.push_back(e);
    endtask

    // Trigger is sampled on the next edge (edge k); returns at the observation of edge k.
    task automatic start_frame(input logic [15:0] a, input logic [15:0] b);
        frame1 = a;
        frame2 = b;
        push_frame(a, b);
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at, output logic err);
        at  = -1;
        err = 1'b0;
        for (int j = 1; j <= budget; j++) begin
            step();
            if (bus.data_valid || bus.frame_err) begin
                at  = j;
                err = bus.frame_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total = total + 1;
        if ({bus.adc_cs_n, bus.adc_sclk, bus.busy, bus.data_valid, bus.frame_err, bus.overrun} !== 6'b110000) begin
            bad = bad + 1;
            $display("FAIL reset_ctl got %b want 110000",
                     {bus.adc_cs_n, bus.adc_sclk, bus.busy, bus.data_valid, bus.frame_err, bus.overrun});
        end
        total = total + 1;
        if ({bus.Vdc1, bus.Vdc2} !== 28'd0) begin
            bad = bad + 1;
            $display("FAIL reset_vdc got v1=%0d v2=%0d want 0 0", bus.Vdc1, bus.Vdc2);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int   cs_low, rises, vcnt, vat;
        logic sp;
        start_frame(16'h0AE1, 16'h033A);
        total = total + 1;
        if ({bus.adc_cs_n, bus.busy} !== 2'b01) begin
            bad = bad + 1;
            $display("FAIL basic_start got cs_n=%0b busy=%0b want 0 1", bus.adc_cs_n, bus.busy);
        end
        cs_low = 1; rises = 0; vcnt = 0; vat = -1; sp = bus.adc_sclk;
        for (int j = 1; j <= 70; j++) begin
            step();
            if (!bus.adc_cs_n) cs_low++;
            if (bus.adc_sclk && !sp) rises++;
            sp = bus.adc_sclk;
            if (bus.data_valid) begin
                vcnt++;
                vat = j;
            end
        end
        total = total + 1;
        if (vat != 66 || vcnt != 1) begin
            bad = bad + 1;
            $display("FAIL basic_latency got at=%0d count=%0d want at=66 count=1", vat, vcnt);
        end
        total = total + 1;
        if (rises != 16) begin
            bad = bad + 1;
            $display("FAIL basic_sclk_rises got %0d want 16", rises);
        end
        total = total + 1;
        if (cs_low != 66) begin
            bad = bad + 1;
            $display("FAIL basic_cs_low got %0d want 66", cs_low);
        end
        total = total + 1;
        if (bus.Vdc1 !== 14'd2785 || bus.Vdc2 !== 14'd826) begin
            bad = bad + 1;
            $display("FAIL basic_codes got v1=%0d v2=%0d want 2785 826", bus.Vdc1, bus.Vdc2);
        end
    endtask

    task automatic test_overrun();
        logic [127:0] mask, exp_mask;
        logic         busy66, busy67, cs67, e;
        int           vat, at;
        start_frame(16'h0AE1, 16'h033A);
        mask = '0; exp_mask = '0; exp_mask[11] = 1'b1; exp_mask[67] = 1'b1;
        vat = -1; busy66 = 1'b1; busy67 = 1'b0; cs67 = 1'b1;
        for (int j = 1; j <= 70; j++) begin
            if (j == 67) push_frame(16'h0AE1, 16'h033A);
            bus.trigger = (j == 10 || j == 66 || j == 67);
            step();
            bus.trigger = 1'b0;
            if (bus.overrun) mask[j] = 1'b1;
            if (bus.data_valid) vat = j;
            if (j == 66) busy66 = bus.busy;
            if (j == 67) begin
                busy67 = bus.busy;
                cs67   = bus.adc_cs_n;
            end
        end
        total = total + 1;
        if (mask !== exp_mask) begin
            bad = bad + 1;
            $display("FAIL overrun_pulses got %h want %h", mask, exp_mask);
        end
        total = total + 1;
        if (vat != 66) begin
            bad = bad + 1;
            $display("FAIL overrun_first_valid got %0d want 66", vat);
        end
        total = total + 1;
        if ({busy66, busy67, cs67} !== 3'b010) begin
            bad = bad + 1;
            $display("FAIL overrun_reaccept got busy66=%0b busy67=%0b cs67=%0b want 0 1 0", busy66, busy67, cs67);
        end
        wait_done(80, at, e);
        total = total + 1;
        if (at != 63 || e !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL overrun_second_frame got at=%0d err=%0b want at=63 err=0", at, e);
        end
        total = total + 1;
        if (bus.Vdc1 !== 14'd2785 || bus.Vdc2 !== 14'd826) begin
            bad = bad + 1;
            $display("FAIL overrun_codes got v1=%0d v2=%0d want 2785 826", bus.Vdc1, bus.Vdc2);
        end
    endtask

    task automatic test_reset_mid();
        int   rises, at;
        logic sp, e;
        start_frame(16'h0AE1, 16'h033A);
        rises = 0; sp = bus.adc_sclk;
        for (int j = 1; j <= 60 && rises < 8; j++) begin
            step();
            if (bus.adc_sclk && !sp) rises++;
            sp = bus.adc_sclk;
        end
        total = total + 1;
        if (rises != 8) begin
            bad = bad + 1;
            $display("FAIL rstmid_reach got rises=%0d want 8", rises);
        end
        rst = 1'b1;
        #1;
        total = total + 1;
        if ({bus.adc_cs_n, bus.adc_sclk, bus.busy} !== 3'b110 || {bus.Vdc1, bus.Vdc2} !== 28'd0) begin
            bad = bad + 1;
            $display("FAIL rstmid_pins got cs_n=%0b sclk=%0b busy=%0b v1=%0d v2=%0d want 1 1 0 0 0",
                     bus.adc_cs_n, bus.adc_sclk, bus.busy, bus.Vdc1, bus.Vdc2);
        end
        sb.delete();
        m_v1 = '0; m_v2 = '0; m_p1 = '0; m_p2 = '0; m_have = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        start_frame(16'h2ABC, 16'h1555);
        wait_done(80, at, e);
        total = total + 1;
        if (at != 66 || e !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL rstmid_next_frame got at=%0d err=%0b want at=66 err=0", at, e);
        end
        total = total + 1;
        if (bus.Vdc1 !== 14'h2ABC || bus.Vdc2 !== 14'h1555) begin
            bad = bad + 1;
            $display("FAIL rstmid_codes got v1=%0d v2=%0d want 10940 5461", bus.Vdc1, bus.Vdc2);
        end
    endtask

    task automatic test_ce();
        logic sclk_s, cs_s, e;
        int   moved, at;
        start_frame(16'h0AE1, 16'h033A);
        repeat (20) step();
        sclk_s = bus.adc_sclk;
        cs_s   = bus.adc_cs_n;
        bus.CE = 1'b0;
        moved  = 0;
        repeat (10) begin
            step();
            if (bus.adc_sclk !== sclk_s || bus.adc_cs_n !== cs_s || bus.data_valid) moved++;
        end
        bus.CE = 1'b1;
        total = total + 1;
        if (moved != 0) begin
            bad = bad + 1;
            $display("FAIL ce_freeze got %0d changed cycles want 0", moved);
        end
        wait_done(80, at, e);
        total = total + 1;
        if (at + 30 != 76 || e !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL ce_latency got at=%0d err=%0b want at=76 err=0", at + 30, e);
        end
    endtask

    task automatic test_frame_err();
        int   at;
        logic e;
        start_frame(16'h0AE1, 16'h433A);
        wait_done(80, at, e);
        total = total + 1;
        if (at != 66 || e !== 1'b1 || bus.data_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL ferr_pulse got at=%0d err=%0b valid=%0b want at=66 err=1 valid=0", at, e, bus.data_valid);
        end
        total = total + 1;
        if (bus.Vdc1 !== m_v1 || bus.Vdc2 !== m_v2) begin
            bad = bad + 1;
            $display("FAIL ferr_hold got v1=%0d v2=%0d want %0d %0d", bus.Vdc1, bus.Vdc2, m_v1, m_v2);
        end
    endtask

    task automatic test_avg();
        int          at;
        logic        e;
        logic [13:0] want2;
`ifdef ADC_AVG_EN
        want2 = 14'd2786;
`else
        want2 = 14'd2788;
`endif
        start_frame(16'h0AE1, 16'h033A);
        wait_done(80, at, e);
        total = total + 1;
        if (at != 66 || bus.Vdc1 !== 14'd2785) begin
            bad = bad + 1;
            $display("FAIL avg_first got at=%0d v1=%0d want at=66 v1=2785", at, bus.Vdc1);
        end
        step();
        start_frame(16'h0AE4, 16'h033A);
        wait_done(80, at, e);
        total = total + 1;
        if (at != 66 || bus.Vdc1 !== want2) begin
            bad = bad + 1;
            $display("FAIL avg_second got at=%0d v1=%0d want at=66 v1=%0d", at, bus.Vdc1, want2);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.CE       = 1'b1;
        bus.trigger  = 1'b0;
        frame1       = '0;
        frame2       = '0;
        test_reset();
        test_basic();
        step();
        test_overrun();
        step();
        test_reset_mid();
        step();
        test_ce();
        step();
        test_frame_err();
        step();
        test_avg();
        repeat (3) step();
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
